// File: rtl/interval_timer_ctrl.sv
// Interval timer: a WIDTH-bit up-counter that wraps on a programmable terminal
// value and emits a registered one-cycle TICK per period (periodic or one-shot).
module interval_timer_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             STOP,
    input  logic [WIDTH-1:0] PERIOD,
    input  logic             ONESHOT,
    output logic             BUSY,
    output logic             DONE,
    output logic             TICK,
    output logic [WIDTH-1:0] O,
    output logic             COUT
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_period, w_period_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic             r_oneshot, w_oneshot_nxt;
    logic             r_tick, w_tick_nxt;
    logic             r_cout, w_cout_nxt;
    logic [WIDTH:0]   w_sum;

    // Carry is kept only as a diagnostic; wrap is decided by the compare.
    assign w_sum = {1'b0, r_cnt} + {{WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_period_nxt  = r_period;
        w_oneshot_nxt = r_oneshot;
        w_cnt_nxt     = '0;
        w_tick_nxt    = 1'b0;
        w_cout_nxt    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (START && !STOP) begin
                    w_period_nxt  = PERIOD;
                    w_oneshot_nxt = ONESHOT;
                    w_state_nxt   = S_RUN;
                end else if (STOP) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (STOP) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == r_period) begin
                    w_tick_nxt = 1'b1;
                    if (r_oneshot) w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt  = w_sum[WIDTH-1:0];
                    w_cout_nxt = w_sum[WIDTH];
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_period  <= '0;
            r_oneshot <= 1'b0;
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_cout    <= 1'b0;
        end else begin
            r_period  <= w_period_nxt;
            r_oneshot <= w_oneshot_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tick    <= w_tick_nxt;
            r_cout    <= w_cout_nxt;
        end
    end

    assign BUSY = (r_state == S_RUN);
    assign DONE = (r_state == S_DONE);
    assign TICK = r_tick;
    assign O    = r_cnt;
    assign COUT = r_cout;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl (WIDTH=4): hand-computed counts,
// tick positions, one-shot completion, abort and reset behaviour.
module tb_interval_timer_ctrl;

    localparam int WIDTH = 4;

    logic             CLK = 1'b0;
    logic             RESET, START, STOP, ONESHOT;
    logic [WIDTH-1:0] PERIOD;
    logic             BUSY, DONE, TICK, COUT;
    logic [WIDTH-1:0] O;

    int vectors = 0;
    int fails   = 0;

    interval_timer_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP),
        .PERIOD(PERIOD), .ONESHOT(ONESHOT),
        .BUSY(BUSY), .DONE(DONE), .TICK(TICK), .O(O), .COUT(COUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, check BUSY/DONE exclusivity.
    task automatic step();
        @(posedge CLK);
        #1;
        chk("busy_done_excl", 8'(BUSY & DONE), 8'd0);
    endtask

    task automatic chk_all(input string tag, input logic b, input logic d,
                           input logic t, input int o);
        chk({tag, ".BUSY"}, 8'(BUSY), 8'(b));
        chk({tag, ".DONE"}, 8'(DONE), 8'(d));
        chk({tag, ".TICK"}, 8'(TICK), 8'(t));
        chk({tag, ".O"},    8'(O),    8'(o));
        chk({tag, ".COUT"}, 8'(COUT), 8'd0);
    endtask

    initial begin
        RESET = 1'b1; START = 1'b1; STOP = 1'b0; ONESHOT = 1'b0; PERIOD = 4'd3;

        // 1: reset held 3 cycles with START asserted
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("reset", 0, 0, 0, 0);
        end
        RESET = 1'b0; START = 1'b0;
        step();
        chk_all("idle", 0, 0, 0, 0);

        // 2: periodic, PERIOD=3
        PERIOD = 4'd3; ONESHOT = 1'b0; START = 1'b1;
        step();
        START = 1'b0;
        chk_all("p3.start", 1, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            START = (k == 2);             // START mid-run is ignored
            step();
            chk_all($sformatf("p3.k%0d", k), 1, 0, (k % 4) == 0, k % 4);
        end
        START = 1'b0; STOP = 1'b1;
        step();
        STOP = 1'b0;
        chk_all("p3.stop", 0, 0, 0, 0);

        // 3: one-shot, PERIOD=5; PERIOD change after start has no effect
        PERIOD = 4'd5; ONESHOT = 1'b1; START = 1'b1;
        step();
        START = 1'b0; PERIOD = 4'd2; ONESHOT = 1'b0;
        chk_all("os.start", 1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_all($sformatf("os.k%0d", k), 1, 0, 0, k);
        end
        step();
        chk_all("os.tick", 0, 1, 1, 0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk_all("os.done", 0, 1, 0, 0);
        end
        PERIOD = 4'd1; ONESHOT = 1'b0; START = 1'b1;
        step();
        START = 1'b0;
        chk_all("os.restart", 1, 0, 0, 0);
        step();
        chk_all("os.r1", 1, 0, 0, 1);
        step();
        chk_all("os.r2", 1, 0, 1, 0);
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        chk_all("os.stop", 0, 0, 0, 0);

        // 4: full range PERIOD=15, COUT must stay 0
        PERIOD = 4'hF; START = 1'b1;
        step();
        START = 1'b0;
        chk_all("full.start", 1, 0, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            step();
            chk_all($sformatf("full.k%0d", k), 1, 0, k == 16, k % 16);
        end
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        chk_all("full.stop", 0, 0, 0, 0);

        // 5: abort at O=2, then START+STOP together in IDLE
        PERIOD = 4'd7; START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        chk_all("abort.o2", 1, 0, 0, 2);
        STOP = 1'b1;
        step();
        chk_all("abort.stop", 0, 0, 0, 0);
        START = 1'b1;
        step();
        chk_all("abort.both", 0, 0, 0, 0);
        START = 1'b0; STOP = 1'b0;
        step();
        chk_all("abort.idle", 0, 0, 0, 0);

        // 6: PERIOD=0 periodic, mid-run PERIOD change, then mid-run reset
        PERIOD = 4'd0; START = 1'b1;
        step();
        START = 1'b0;
        chk_all("p0.start", 1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_all($sformatf("p0.k%0d", k), 1, 0, 1, 0);
        end
        PERIOD = 4'd9;
        for (int k = 5; k <= 7; k++) begin
            step();
            chk_all($sformatf("p0.k%0d", k), 1, 0, 1, 0);
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk_all("p0.reset", 0, 0, 0, 0);
        step();
        chk_all("p0.after", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
